// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Issues one instruction-memory request at a time for the PC supplied by the
// fetch stage, hands returned words to the IF/ID register and stalls the PC
// register until a word is delivered. Handles load-use back-pressure with a
// one-entry hold buffer and branch redirects by squashing the in-flight fetch.
// A watchdog moves the controller into a sticky error state when memory stops
// making progress. Only reset leaves the error state.
module fetch_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pcsrc_i,
  input  logic        pipe_stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        stall_pipeline_o,
  output logic        flush_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        fetch_err_o
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  // S_WAIT: grant received, response still owed and wanted.
  // S_DROP: grant received, response still owed but must be thrown away.
  // S_HOLD: response captured in the buffer while decode is stalled.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DROP = 3'd3,
    S_HOLD = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;

  logic progress;   // memory moved forward this cycle (grant or response)
  logic timed;      // state in which the watchdog is running
  logic redirect;   // redirect that this state is allowed to act on

  assign progress = ((state_q == S_REQ) && imem_gnt_i) ||
                    (((state_q == S_WAIT) || (state_q == S_DROP)) && imem_rvalid_i);
  assign timed    = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DROP);
  assign redirect = pcsrc_i && (state_q != S_IDLE) && (state_q != S_ERR);

  assign fetch_err_o = err_q;

  // Output decode: memory and pipeline controls follow the state and the
  // inputs in the same cycle so a zero-wait memory needs no bubble.
  always_comb begin
    // NOTE: every output gets a value before the case statement so that no
    // path leaves one unassigned, which would otherwise infer a latch.
    imem_req_o       = 1'b0;
    imem_addr_o      = 32'd0;
    stall_pipeline_o = 1'b1;
    flush_o          = 1'b0;
    instr_o          = 32'd0;
    instr_valid_o    = 1'b0;

    case (state_q)
      S_REQ: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_i;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          instr_o          = imem_rdata_i;
          instr_valid_o    = 1'b1;
          stall_pipeline_o = pipe_stall_i;
        end
      end
      S_HOLD: begin
        instr_o          = buf_q;
        instr_valid_o    = 1'b1;
        stall_pipeline_o = pipe_stall_i;
      end
      default: ;
    endcase

    // A redirect lets the PC register load the target and kills whatever
    // instruction would have entered IF/ID, regardless of decode stalls.
    if (redirect) begin
      stall_pipeline_o = 1'b0;
      flush_o          = 1'b1;
      instr_valid_o    = 1'b0;
      instr_o          = 32'd0;
    end
  end

  // Next-state, hold buffer and watchdog computation.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          // A grant taken in the redirect cycle fetched the stale PC.
          state_d = pcsrc_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (!pcsrc_i && pipe_stall_i) begin
            state_d = S_HOLD;
            buf_d   = imem_rdata_i;
          end else begin
            state_d = S_REQ;
          end
        end else if (pcsrc_i) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (pcsrc_i || !pipe_stall_i) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        // The owed response still has to be absorbed even if another
        // redirect arrives meanwhile; the PC register already holds it.
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // The watchdog fires on the last allowed idle cycle and wins over any
    // other transition, including a redirect.
    if (timed && !progress && (cnt_q == CNT_LAST)) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end

    if ((state_d != state_q) || progress || !timed) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      // NOTE: the hold buffer is a single register, not a memory array, so it
      // is cleared on reset along with the rest of the state.
      buf_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous state, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

endmodule
